// File: rtl/vga_scan_out.sv
// Raster scan generator and VGA output stage: sweeps the frame, hands the pixel
// coordinate to the renderer and registers sync/DE/RGB aligned to its returned colour.
module vga_scan_out #(
   parameter int          PIX_WIDTH    = 12,
   parameter int          H_ACTIVE     = 1280,
   parameter int          H_FP         = 48,
   parameter int          H_SYNC       = 112,
   parameter int          H_BP         = 248,
   parameter int          V_ACTIVE     = 1024,
   parameter int          V_FP         = 1,
   parameter int          V_SYNC       = 3,
   parameter int          V_BP         = 38,
   parameter bit          HS_POL       = 1'b1,
   parameter bit          VS_POL       = 1'b1,
   parameter int          DATA_LATENCY = 1,
   parameter logic [23:0] BG_COLOR     = 24'h000000
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   output logic [PIX_WIDTH-1:0] pix_x_o,
   output logic [PIX_WIDTH-1:0] pix_y_o,
   output logic                 pix_active_o,
   output logic                 frame_start_o,
   input  logic [23:0]          vga_data_i,
   input  logic                 vga_data_en_i,
   output logic                 vga_hs_o,
   output logic                 vga_vs_o,
   output logic                 vga_de_o,
   output logic [7:0]           vga_r_o,
   output logic [7:0]           vga_g_o,
   output logic [7:0]           vga_b_o
);

   localparam logic [PIX_WIDTH-1:0] H_LAST   = PIX_WIDTH'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [PIX_WIDTH-1:0] V_LAST   = PIX_WIDTH'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [PIX_WIDTH-1:0] H_ACT    = PIX_WIDTH'(H_ACTIVE);
   localparam logic [PIX_WIDTH-1:0] V_ACT    = PIX_WIDTH'(V_ACTIVE);
   localparam logic [PIX_WIDTH-1:0] HS_START = PIX_WIDTH'(H_ACTIVE + H_FP);
   localparam logic [PIX_WIDTH-1:0] HS_END   = PIX_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [PIX_WIDTH-1:0] VS_START = PIX_WIDTH'(V_ACTIVE + V_FP);
   localparam logic [PIX_WIDTH-1:0] VS_END   = PIX_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } timing_t;

   logic [PIX_WIDTH-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic [PIX_WIDTH-1:0] pix_x_q, pix_y_q;
   logic                 frame_start_q;
   timing_t              tim_q, tim_dly;
   logic                 hs_q, vs_q, de_q;
   logic [23:0]          rgb_q;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end
   end

   // Counters lead the coordinate outputs by one clock so (0,0) is shown on the first edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_start_q <= 1'b0;
         tim_q         <= '0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pix_x_q       <= h_cnt_q;
         pix_y_q       <= v_cnt_q;
         frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
         tim_q.act     <= (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
         tim_q.hs      <= (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
         tim_q.vs      <= (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
      end
   end

   generate
      if (DATA_LATENCY == 0) begin : g_no_dly
         assign tim_dly = tim_q;
      end else begin : g_dly
         timing_t dly_q [DATA_LATENCY];
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               for (int i = 0; i < DATA_LATENCY; i++) dly_q[i] <= '0;
            end else begin
               dly_q[0] <= tim_q;
               for (int i = 1; i < DATA_LATENCY; i++) dly_q[i] <= dly_q[i-1];
            end
         end
         assign tim_dly = dly_q[DATA_LATENCY-1];
      end
   endgenerate

   // NOTE: sync pins reset to their inactive level, which depends on polarity, not to 0.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hs_q  <= ~HS_POL;
         vs_q  <= ~VS_POL;
         de_q  <= 1'b0;
         rgb_q <= '0;
      end else begin
         hs_q  <= tim_dly.hs ? HS_POL : ~HS_POL;
         vs_q  <= tim_dly.vs ? VS_POL : ~VS_POL;
         de_q  <= tim_dly.act;
         if (!tim_dly.act)      rgb_q <= '0;
         else if (vga_data_en_i) rgb_q <= vga_data_i;
         else                    rgb_q <= BG_COLOR;
      end
   end

   assign pix_x_o       = pix_x_q;
   assign pix_y_o       = pix_y_q;
   assign pix_active_o  = tim_q.act;
   assign frame_start_o = frame_start_q;
   assign vga_hs_o      = hs_q;
   assign vga_vs_o      = vs_q;
   assign vga_de_o      = de_q;
   assign vga_r_o       = rgb_q[23:16];
   assign vga_g_o       = rgb_q[15:8];
   assign vga_b_o       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_out.sv
// Self-checking bench for vga_scan_out on a shrunken 16x11 raster with a 2-clock renderer.
module tb_vga_scan_out;
   localparam int HA = 8, HF = 2, HSW = 3, HB = 3, HT = HA + HF + HSW + HB;
   localparam int VA = 6, VF = 1, VSW = 2, VB = 2, VT = VA + VF + VSW + VB;
   localparam int LAT = 2;
   localparam logic [23:0] BG = 24'h123456;
   localparam bit HSP = 1'b1, VSP = 1'b0;

   typedef struct packed {
      logic [23:0] rgb;
      logic        de;
      logic        hs;
      logic        vs;
   } out_t;

   typedef struct packed {
      logic        en;
      logic [23:0] data;
   } drv_t;

   typedef struct {
      int          x;
      int          y;
      logic        en;
      logic [23:0] data;
      out_t        exp;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [11:0] pix_x, pix_y;
   logic        pix_active, frame_start;
   logic [23:0] data_i = '0;
   logic        en_i = 1'b0;
   logic        hs, vs, de;
   logic [7:0]  r, g, b;

   vga_scan_out #(
      .PIX_WIDTH(12), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(HSP), .VS_POL(VSP), .DATA_LATENCY(LAT), .BG_COLOR(BG)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_active_o(pix_active), .frame_start_o(frame_start),
      .vga_data_i(data_i), .vga_data_en_i(en_i),
      .vga_hs_o(hs), .vga_vs_o(vs), .vga_de_o(de),
      .vga_r_o(r), .vga_g_o(g), .vga_b_o(b)
   );

   always #5 clk = ~clk;

   int   checks = 0, errors = 0;
   int   mx, my, step_no, last_fs;
   out_t exp_q[$];
   drv_t drv_q[$];
   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(int x, int y, logic en, logic [23:0] data,
                               logic [23:0] rgb, logic de_e, logic hs_e, logic vs_e);
      vec_t v;
      v.x = x; v.y = y; v.en = en; v.data = data;
      v.exp.rgb = rgb; v.exp.de = de_e; v.exp.hs = hs_e; v.exp.vs = vs_e;
      return v;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, " pix_x"}, 32'(pix_x), 32'd0);
      check({tag, " pix_y"}, 32'(pix_y), 32'd0);
      check({tag, " active"}, 32'(pix_active), 32'd0);
      check({tag, " frame_start"}, 32'(frame_start), 32'd0);
      check({tag, " hs"}, 32'(hs), 32'(!HSP));
      check({tag, " vs"}, 32'(vs), 32'(!VSP));
      check({tag, " de"}, 32'(de), 32'd0);
      check({tag, " rgb"}, 32'({r, g, b}), 32'd0);
   endtask

   // Restart the scoreboard: the first LAT+1 output edges still show the cleared pipeline.
   task automatic restart_model();
      out_t idle;
      idle.rgb = '0; idle.de = 1'b0; idle.hs = !HSP; idle.vs = !VSP;
      exp_q.delete();
      drv_q.delete();
      for (int i = 0; i <= LAT; i++) exp_q.push_back(idle);
      mx = 0; my = 0; step_no = 0; last_fs = -1;
      data_i = '0; en_i = 1'b0;
   endtask

   task automatic step();
      out_t e, got;
      drv_t d;
      @(posedge clk);
      @(negedge clk);
      step_no++;
      check($sformatf("pix_x@%0d,%0d", mx, my), 32'(pix_x), 32'(mx));
      check($sformatf("pix_y@%0d,%0d", mx, my), 32'(pix_y), 32'(my));
      check($sformatf("active@%0d,%0d", mx, my), 32'(pix_active), 32'(mx < HA && my < VA));
      check($sformatf("frame_start@%0d,%0d", mx, my), 32'(frame_start), 32'(mx == 0 && my == 0));
      if (frame_start === 1'b1) begin
         if (last_fs >= 0) check("frame_period", 32'(step_no - last_fs), 32'(HT * VT));
         last_fs = step_no;
      end
      e.de = (mx < HA) && (my < VA);
      if (e.de) begin
         d.en   = 1'($urandom_range(0, 1));
         d.data = {mx[11:0], my[11:0]};
      end else begin
         d.en   = 1'b1;
         d.data = 24'hFFFFFF;
      end
      e.rgb = e.de ? (d.en ? d.data : BG) : 24'h0;
      e.hs  = (mx >= HA + HF && mx < HA + HF + HSW) ? HSP : !HSP;
      e.vs  = (my >= VA + VF && my < VA + VF + VSW) ? VSP : !VSP;
      foreach (vecs[i]) begin
         if (vecs[i].x == mx && vecs[i].y == my) begin
            d.en = vecs[i].en; d.data = vecs[i].data; e = vecs[i].exp;
         end
      end
      exp_q.push_back(e);
      drv_q.push_back(d);
      got.rgb = {r, g, b}; got.de = de; got.hs = hs; got.vs = vs;
      e = exp_q.pop_front();
      check($sformatf("rgb@%0t", $time), 32'(got.rgb), 32'(e.rgb));
      check($sformatf("de@%0t", $time), 32'(got.de), 32'(e.de));
      check($sformatf("hs@%0t", $time), 32'(got.hs), 32'(e.hs));
      check($sformatf("vs@%0t", $time), 32'(got.vs), 32'(e.vs));
      if (drv_q.size() > LAT) begin
         d = drv_q.pop_front();
         data_i = d.data;
         en_i   = d.en;
      end
      if (mx == HT - 1) begin
         mx = 0;
         my = (my == VT - 1) ? 0 : my + 1;
      end else begin
         mx++;
      end
   endtask

   initial begin
      //            x   y  en  data         rgb          de    hs    vs (VS active low)
      vecs[0]  = mk(0,  0, 0, 24'hAAAAAA, BG,          1'b1, 1'b0, 1'b1);
      vecs[1]  = mk(5,  3, 1, 24'h005003, 24'h005003, 1'b1, 1'b0, 1'b1);
      vecs[2]  = mk(7,  5, 1, 24'hABCDEF, 24'hABCDEF, 1'b1, 1'b0, 1'b1);
      vecs[3]  = mk(6,  1, 0, 24'hFFFFFF, BG,          1'b1, 1'b0, 1'b1);
      vecs[4]  = mk(8,  2, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1);
      vecs[5]  = mk(9,  0, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1);
      vecs[6]  = mk(10, 1, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1, 1'b1);
      vecs[7]  = mk(12, 4, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1, 1'b1);
      vecs[8]  = mk(13, 4, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1);
      vecs[9]  = mk(3,  6, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1);
      vecs[10] = mk(3,  7, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b0);
      vecs[11] = mk(11, 8, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b1, 1'b0);
      vecs[12] = mk(0,  9, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1);
      vecs[13] = mk(15, 10, 1, 24'hFFFFFF, 24'h000000, 1'b0, 1'b0, 1'b1);

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("por");

      restart_model();
      rst_n = 1'b1;
      // One full frame plus scan up to pixel (5,3) of the next frame.
      for (int i = 0; i < HT * VT + 3 * HT + 6; i++) step();

      #1 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      @(negedge clk);
      check_reset_values("held_rst");
      restart_model();
      rst_n = 1'b1;
      for (int i = 0; i < HT * VT + 2 * HT; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
